dmem_lsu: RTL and testbench

//  Parametrised word-organised data memory with RISC-V load/store semantics.
//  - Byte, half and word accesses with sign/zero extension.
//  - Synchronous writes; valid/ready request and response channels.
//  - Programmable access latency; alignment and range checking.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_lsu_if.sv | 37 +++
 rtl/dmem_align.sv | 59 +++++
 rtl/dmem_lsu.sv | 191 +++++++++++++++++++
 tb/tb_dmem_lsu.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// +---------------------------------------------------------------------------+
// | Module   : dmem_pkg                                                       |
// | Purpose  : Shared types for the data-memory load/store unit: RISC-V      |
// |            access-size encoding, FSM state encoding and a helper that     |
// |            sizes the latency counter.                                     |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

  // Access size, encoded exactly as RISC-V load/store funct3.
  typedef enum logic [2:0] {
    SZ_B  = 3'd0,
    SZ_H  = 3'd1,
    SZ_W  = 3'd2,
    SZ_BU = 3'd4,
    SZ_HU = 3'd5
  } size_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // The WAIT counter is loaded with LATENCY-2 and counts down to zero,
  // so it only has to hold values up to LATENCY-2.
  function automatic int lat_cnt_w(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lsu_if.sv
// +---------------------------------------------------------------------------+
// | Module   : dmem_lsu_if                                                    |
// | Purpose  : Request/response bus between the MEM stage (master) and the   |
// |            data-memory LSU (slave).                                       |
// | Ports    : req_valid/req_ready/req_we/req_size/req_addr/req_wdata,       |
// |            rsp_valid/rsp_ready/rsp_rdata/rsp_err, init_done              |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

interface dmem_lsu_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

`default_nettype wire

// File: rtl/dmem_align.sv
// +---------------------------------------------------------------------------+
// | Module   : dmem_align                                                     |
// | Purpose  : Combinational lane logic: byte enables, store-data steering,  |
// |            load extraction with sign/zero extension, and the alignment / |
// |            illegal-size error flag.                                       |
// | Ports    : size, lane, wdata, rword (in); be, wword, rdata, err (out)    |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        err
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be     = 4'b0000;
    wword  = 32'h0;
    rdata  = 32'h0;
    err    = 1'b0;
    byte_v = rword[{lane, 3'b000} +: 8];
    half_v = lane[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_B, SZ_BU: begin
        be    = 4'b0001 << lane;
        // Replicate so the byte lands on whichever lane the enable selects.
        wword = {4{wdata[7:0]}};
        rdata = (size == SZ_B) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      end
      SZ_H, SZ_HU: begin
        err   = lane[0];
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = (size == SZ_H) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      end
      SZ_W: begin
        err   = |lane;
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_lsu.sv
// +---------------------------------------------------------------------------+
// | Module   : dmem_lsu                                                       |
// | Purpose  : Word-organised data memory with RISC-V load/store semantics,  |
// |            valid/ready request and response channels, programmable       |
// |            access latency and alignment/range checking.                  |
// | Ports    : clk, rst (async, active-high), bus (dmem_lsu_if.slave)        |
// | Params   : DEPTH (words, power of two), LATENCY (1..8), ADDR_W           |
// | Options  : DMEM_RESET_INIT_EN - zero every word after reset release,     |
// |            one word per cycle, before accepting requests.                |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32
) (
  input  logic       clk,
  input  logic       rst,
  dmem_lsu_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = lat_cnt_w(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [2:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [31:0]         mem [DEPTH];

  logic                w_accept, w_commit, w_live;
  logic                w_c_we;
  logic [2:0]          w_c_size;
  logic [ADDR_W-1:0]   w_c_addr;
  logic [31:0]         w_c_wdata;
  logic [IDX_W-1:0]    w_idx;
  logic                w_oor, w_align_err, w_err, w_mem_we;
  logic [3:0]          w_be;
  logic [31:0]         w_wword, w_ld_data, w_rword;
  logic                w_init_we, w_init_last;
  logic [IDX_W-1:0]    w_init_idx;

  assign w_accept = bus.req_valid && (state_q == ST_IDLE);
  // With LATENCY=1 the access commits on the accept edge itself, so the
  // live request fields feed the datapath; otherwise the latched copies do.
  assign w_live   = (state_q == ST_IDLE);
  assign w_commit = (LATENCY == 1) ? w_accept : ((state_q == ST_WAIT) && (cnt_q == '0));

  assign w_c_we    = w_live ? bus.req_we    : we_q;
  assign w_c_size  = w_live ? bus.req_size  : size_q;
  assign w_c_addr  = w_live ? bus.req_addr  : addr_q;
  assign w_c_wdata = w_live ? bus.req_wdata : wdata_q;

  assign w_idx    = w_c_addr[IDX_W+1:2];
  assign w_rword  = mem[w_idx];
  assign w_err    = w_align_err | w_oor;
  assign w_mem_we = w_commit & w_c_we & ~w_err;

  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign w_oor = |w_c_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
      assign w_oor = 1'b0;
    end
  endgenerate

  dmem_align u_align (
    .size  (w_c_size),
    .lane  (w_c_addr[1:0]),
    .wdata (w_c_wdata),
    .rword (w_rword),
    .be    (w_be),
    .wword (w_wword),
    .rdata (w_ld_data),
    .err   (w_align_err)
  );

`ifdef DMEM_RESET_INIT_EN
  logic [IDX_W-1:0] init_idx_q, init_idx_d;

  always_comb begin
    init_idx_d = init_idx_q;
    if (state_q == ST_INIT) init_idx_d = init_idx_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) init_idx_q <= '0;
    else     init_idx_q <= init_idx_d;
  end

  assign w_init_we   = (state_q == ST_INIT);
  assign w_init_idx  = init_idx_q;
  assign w_init_last = (init_idx_q == IDX_W'(DEPTH - 1));
`else
  assign w_init_we   = 1'b0;
  assign w_init_idx  = '0;
  assign w_init_last = 1'b1;
`endif

  // Storage is deliberately not reset: contents survive rst unless the
  // init sweep is enabled.
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      mem[w_init_idx] <= 32'h0;
    end else if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (w_init_last) state_d = ST_IDLE;
      ST_IDLE: if (bus.req_valid) state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (w_accept) begin
      cnt_d   = CNT_LOAD;
      we_d    = bus.req_we;
      size_d  = bus.req_size;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (w_commit) begin
      err_d   = w_err;
      rdata_d = (w_c_we || w_err) ? 32'h0 : w_ld_data;
    end
  end

  // FSM: state register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // FSM: outputs
  always_comb begin
    bus.req_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP);
    bus.init_done = (state_q != ST_INIT);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// +---------------------------------------------------------------------------+
// | Module   : tb_dmem_lsu                                                    |
// | Purpose  : Self-checking bench for dmem_lsu against a byte-addressed     |
// |            little-endian reference memory. Honours DMEM_RESET_INIT_EN.   |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_lsu;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 3;
  localparam int ADDR_W  = 32;
`ifdef DMEM_RESET_INIT_EN
  localparam int INIT_LEN = DEPTH;
`else
  localparam int INIT_LEN = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] ref_mem [4*DEPTH];

  dmem_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_lsu #(.DEPTH(DEPTH), .LATENCY(LATENCY), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic [2:0] sz, input logic [31:0] a);
    if (a >= 32'(4*DEPTH)) return 1'b1;
    case (sz)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return a[0];
      3'd2:       return a[1:0] != 2'b00;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] sz);
    return (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nbytes(sz); i++) v |= 32'(ref_mem[a + i]) << (8 * i);
    if (sz == 3'd0 && v[7])  v |= 32'hFFFF_FF00;
    if (sz == 3'd1 && v[15]) v |= 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[a + i] = 8'(wd >> (8 * i));
  endtask

  task automatic ref_reset();
`ifdef DMEM_RESET_INIT_EN
    for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
`endif
  endtask

  // One request/response transaction, checked against the reference model.
  task automatic xact(input logic we, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input int hold, output logic [31:0] got);
    logic [31:0] exp_d;
    logic        exp_e;
    int          n;
    exp_e = ref_err(sz, a);
    exp_d = (we || exp_e) ? 32'h0 : ref_load(sz, a);
    if (we && !exp_e) ref_store(sz, a, wd);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("req_ready_before_accept", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("latency", n, LATENCY);
    check("rsp_rdata", bus.rsp_rdata, exp_d);
    check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, exp_e});
    got = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
      check("hold_rsp_rdata", bus.rsp_rdata, exp_d);
      check("hold_req_ready", {31'h0, bus.req_ready}, 32'h0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("post_hs_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("post_hs_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
  endtask

  // Release reset away from the clock edge and time the init phase.
  task automatic release_and_init();
    int n;
    rst = 1'b0;
    n = 0;
    while (!bus.init_done && n < DEPTH + 20) begin
      @(posedge clk); #1; n++;
      check("init_req_ready", {31'h0, bus.req_ready}, {31'h0, bus.init_done});
    end
    check("init_len", n, INIT_LEN);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] ra, rwd;
    logic [2:0]  rsz;
    logic        rwe;
    for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 3'd0;
    bus.req_addr  = '0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err",   {31'h0, bus.rsp_err}, 32'h0);
    check("rst_init_done", {31'h0, bus.init_done}, 32'h0);
    release_and_init();

    // Bring every word to a known value so the model is fully defined.
    for (int w = 0; w < DEPTH; w++) xact(1'b1, 3'd2, 32'(4*w), 32'h0, 0, got);

    // Basic store/load
    xact(1'b1, 3'd2, 32'h10, 32'h8000_00FF, 0, got);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, got);
    check("t1_lw", got, 32'h8000_00FF);

    // Sub-word accesses
    xact(1'b1, 3'd0, 32'h11, 32'h0000_005A, 0, got);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, got);
    check("t2_lw", got, 32'h8000_5AFF);
    xact(1'b0, 3'd0, 32'h13, 32'h0, 0, got);
    check("t2_lb", got, 32'hFFFF_FF80);
    xact(1'b0, 3'd4, 32'h13, 32'h0, 0, got);
    check("t2_lbu", got, 32'h0000_0080);
    xact(1'b0, 3'd1, 32'h12, 32'h0, 0, got);
    check("t2_lh", got, 32'hFFFF_8000);

    // Error cases
    xact(1'b1, 3'd2, 32'h20, 32'hCAFE_BABE, 0, got);
    xact(1'b1, 3'd1, 32'h21, 32'h0000_1111, 0, got);
    xact(1'b0, 3'd2, 32'h20, 32'h0, 0, got);
    check("t3_lw_unchanged", got, 32'hCAFE_BABE);
    xact(1'b0, 3'd2, 32'h400, 32'h0, 0, got);
    xact(1'b0, 3'd3, 32'h30, 32'h0, 0, got);

    // Backpressure on the response channel
    xact(1'b0, 3'd2, 32'h10, 32'h0, 5, got);

    // Reset during the last WAIT cycle drops the pending store
    xact(1'b1, 3'd2, 32'h40, 32'h1111_2222, 0, got);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 3'd2;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("midrst_req_ready", {31'h0, bus.req_ready}, 32'h0);
    ref_reset();
    @(posedge clk); #1;
    release_and_init();
    xact(1'b0, 3'd2, 32'h40, 32'h0, 0, got);

    // Reset re-initialisation (contents retained when the sweep is off)
    xact(1'b1, 3'd2, 32'h0, 32'h0000_1234, 0, got);
    @(posedge clk); #1;
    rst = 1'b1;
    ref_reset();
    @(posedge clk); #1;
    release_and_init();
    xact(1'b0, 3'd2, 32'h0, 32'h0, 0, got);
    xact(1'b0, 3'd2, 32'h3FC, 32'h0, 0, got);

    // Randomised traffic
    for (int k = 0; k < 80; k++) begin
      rwe = 1'($urandom_range(0, 1));
      rsz = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ra = 32'h400 + 32'($urandom_range(0, 255));
      else                           ra = 32'($urandom_range(0, 4*DEPTH - 1));
      rwd = $urandom;
      xact(rwe, rsz, ra, rwd, int'($urandom_range(0, 2)), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
